// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard receiver that produces the 16-bit Hack key code of the held key.
// Define PS2_PARITY_CHECK_EN to also reject frames whose odd parity does not check.
module ps2_keyboard #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_code,
    output logic        key_strobe,
    output logic        frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   parity_q, parity_d;
    logic [TW-1:0]          timeout_q, timeout_d;
    logic                   byte_valid_q, byte_valid_d;
    logic [7:0]             byte_q, byte_d;
    logic                   ext_q, ext_d;
    logic                   brk_q, brk_d;
    logic [7:0]             key_q, key_d;
    logic                   key_strobe_q, key_strobe_d;
    logic                   frame_err_q, frame_err_d;

    logic                   clk_s_c;
    logic                   dat_s_c;
    logic                   fall_c;
    logic                   frame_ok_c;
    logic [7:0]             hack_c;

    assign clk_s_c = clk_sync_q[SYNC_STAGES-1];
    assign dat_s_c = dat_sync_q[SYNC_STAGES-1];
    assign fall_c  = clk_prev_q & ~clk_s_c;

    assign key_code   = {8'h00, key_q};
    assign key_strobe = key_strobe_q;
    assign frame_err  = frame_err_q;

    // Set-2 scan code to Hack code; 0 means the code is not mapped.
    function automatic logic [7:0] map_code(input logic ext, input logic [7:0] sc);
        logic [7:0] hc;
        hc = 8'd0;
        if (ext) begin
            case (sc)
                8'h6B: hc = 8'd130;
                8'h75: hc = 8'd131;
                8'h74: hc = 8'd132;
                8'h72: hc = 8'd133;
                8'h6C: hc = 8'd134;
                8'h69: hc = 8'd135;
                8'h7D: hc = 8'd136;
                8'h7A: hc = 8'd137;
                8'h70: hc = 8'd138;
                8'h71: hc = 8'd139;
                default: hc = 8'd0;
            endcase
        end else begin
            case (sc)
                8'h1C: hc = 8'd65;  8'h32: hc = 8'd66;  8'h21: hc = 8'd67;
                8'h23: hc = 8'd68;  8'h24: hc = 8'd69;  8'h2B: hc = 8'd70;
                8'h34: hc = 8'd71;  8'h33: hc = 8'd72;  8'h43: hc = 8'd73;
                8'h3B: hc = 8'd74;  8'h42: hc = 8'd75;  8'h4B: hc = 8'd76;
                8'h3A: hc = 8'd77;  8'h31: hc = 8'd78;  8'h44: hc = 8'd79;
                8'h4D: hc = 8'd80;  8'h15: hc = 8'd81;  8'h2D: hc = 8'd82;
                8'h1B: hc = 8'd83;  8'h2C: hc = 8'd84;  8'h3C: hc = 8'd85;
                8'h2A: hc = 8'd86;  8'h1D: hc = 8'd87;  8'h22: hc = 8'd88;
                8'h35: hc = 8'd89;  8'h1A: hc = 8'd90;
                8'h45: hc = 8'd48;  8'h16: hc = 8'd49;  8'h1E: hc = 8'd50;
                8'h26: hc = 8'd51;  8'h25: hc = 8'd52;  8'h2E: hc = 8'd53;
                8'h36: hc = 8'd54;  8'h3D: hc = 8'd55;  8'h3E: hc = 8'd56;
                8'h46: hc = 8'd57;
                8'h29: hc = 8'd32;  8'h5A: hc = 8'd128; 8'h66: hc = 8'd129;
                8'h76: hc = 8'd140;
                8'h05: hc = 8'd141; 8'h06: hc = 8'd142; 8'h04: hc = 8'd143;
                8'h0C: hc = 8'd144; 8'h03: hc = 8'd145; 8'h0B: hc = 8'd146;
                8'h83: hc = 8'd147; 8'h0A: hc = 8'd148; 8'h01: hc = 8'd149;
                8'h09: hc = 8'd150; 8'h78: hc = 8'd151; 8'h07: hc = 8'd152;
                default: hc = 8'd0;
            endcase
        end
        return hc;
    endfunction

    assign hack_c = map_code(ext_q, byte_q);

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok_c = dat_s_c & (^{shift_q, parity_q});
`else
    assign frame_ok_c = dat_s_c;
`endif

    // Next-state: synchronisers, frame receiver, timeout, byte decode.
    always_comb begin
        state_d      = state_q;
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d   = clk_s_c;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        parity_d     = parity_q;
        timeout_d    = timeout_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        key_d        = key_q;
        frame_err_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            timeout_d = '0;
            if (fall_c && !dat_s_c) begin
                state_d   = ST_RECV;
                bit_cnt_d = 3'd0;
            end
        end else if (fall_c) begin
            timeout_d = '0;
            case (state_q)
                ST_RECV: begin
                    shift_d   = {dat_s_c, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = dat_s_c;
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (frame_ok_c) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            endcase
        end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_IDLE;
            timeout_d = '0;
        end else begin
            timeout_d = timeout_q + TW'(1);
        end

        // Prefix bytes only set flags; any other byte consumes and clears them.
        if (byte_valid_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (hack_c != 8'd0) begin
                    if (!brk_q)                key_d = hack_c;
                    else if (hack_c == key_q)  key_d = 8'd0;
                end
            end
        end
        key_strobe_d = (key_d != key_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            clk_prev_q   <= 1'b1;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            parity_q     <= 1'b0;
            timeout_q    <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'd0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            key_q        <= 8'd0;
            key_strobe_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            clk_prev_q   <= clk_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            timeout_q    <= timeout_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            key_q        <= key_d;
            key_strobe_q <= key_strobe_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule
